runner_command_gen: RTL and testbench



---
 rtl/runner_command_gen.sv | 84 ++++++++
 tb/tb_runner_command_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/runner_command_gen.sv
// runner_command_gen: synchronised key edges become one-hot jump/drop commands, held until an update tick, then locked out for the manoeuvre length.
// Define RUNNER_CMD_BUFFER_EN to keep a one-deep pending command captured while busy.
module runner_command_gen #(
  parameter int TICK_DIV    = 833333,
  parameter int GROUND_Y    = 108,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_big,
  input  logic       key_small,
  input  logic       key_drop,
  input  logic [6:0] y_pos,
  output logic [2:0] operation,
  output logic       update,
  output logic       busy
);
  localparam int TW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, ARMED, AIRBORNE} state_t;
  state_t r_state, w_next;
  logic [TW-1:0] r_tick;
  logic [SYNC_STAGES-1:0] r_sb, r_ss, r_sd;
  logic [2:0] r_prev, r_edge, r_op, w_sync, w_edge, w_cand;
  logic [4:0] r_step, r_len;
  logic w_go;
  function automatic logic elig(input logic [2:0] op, input logic [6:0] y);
    return (op[0] | op[1]) ? (y == 7'(GROUND_Y)) : (op[2] & (y < 7'(GROUND_Y)));
  endfunction
  assign update = r_tick == TW'(TICK_DIV - 1);
  assign w_sync = {r_sd[SYNC_STAGES-1], r_ss[SYNC_STAGES-1], r_sb[SYNC_STAGES-1]};
  assign w_edge = r_edge[0] ? 3'b001 : r_edge[1] ? 3'b010 : r_edge[2] ? 3'b100 : 3'b000;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_tick <= '0;
      r_sb   <= '0;
      r_ss   <= '0;
      r_sd   <= '0;
      r_prev <= '0;
      r_edge <= '0;
    end else begin
      r_tick <= update ? '0 : r_tick + TW'(1);
      r_sb   <= {r_sb[SYNC_STAGES-2:0], key_big};
      r_ss   <= {r_ss[SYNC_STAGES-2:0], key_small};
      r_sd   <= {r_sd[SYNC_STAGES-2:0], key_drop};
      r_prev <= w_sync;
      r_edge <= w_sync & ~r_prev;
    end
`ifdef RUNNER_CMD_BUFFER_EN
  logic [2:0] r_pend;
  // an eligible pending command beats a fresh edge on IDLE entry; pending is dropped either way
  assign w_cand = (r_pend != 3'b000 && elig(r_pend, y_pos)) ? r_pend : w_edge;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_pend <= '0;
    else if (r_state == IDLE) r_pend <= '0;
    else if (w_edge != 3'b000) r_pend <= w_edge;
`else
  assign w_cand = w_edge;
`endif
  assign w_go = w_cand != 3'b000 && elig(w_cand, y_pos);
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (w_go ? ARMED : IDLE) :
             r_state == ARMED ? (update ? AIRBORNE : ARMED) :
             (r_state == AIRBORNE && r_step != r_len) ? AIRBORNE : IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_op   <= '0;
      r_len  <= '0;
      r_step <= '0;
    end else begin
      if (r_state == IDLE && w_go) begin
        r_op  <= w_cand;
        r_len <= w_cand[0] ? 5'd10 : w_cand[1] ? 5'd15 : 5'd9;
      end
      if (r_state == ARMED && update) r_step <= 5'd1;
      else if (r_state == AIRBORNE && update) r_step <= r_step + 5'd1;
    end
  always_comb begin
    operation = r_state == ARMED ? r_op : 3'b000;
    busy      = r_state != IDLE;
  end
endmodule

// File: tb/tb_runner_command_gen.sv
// tb_runner_command_gen: randomized and directed checks of runner_command_gen against a timestamp-based reference model.
module tb_runner_command_gen;
  localparam int T = 4, S = 2, GY = 108;
`ifdef RUNNER_CMD_BUFFER_EN
  localparam bit BUF = 1;
`else
  localparam bit BUF = 0;
`endif
  logic clk = 0, reset = 1, key_big = 0, key_small = 0, key_drop = 0;
  logic [6:0] y_pos = 7'd108;
  logic [2:0] operation;
  logic update, busy;
  int errors = 0, checks = 0;
  int n, arm_s, issue_u, idle_at;
  logic [2:0] m_op, pend, e_op;
  logic e_busy, e_upd;
  bit hb[8192], hs[8192], hd[8192];

  runner_command_gen #(.TICK_DIV(T), .GROUND_Y(GY), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .key_big(key_big), .key_small(key_small), .key_drop(key_drop),
    .y_pos(y_pos), .operation(operation), .update(update), .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [2:0] edges(input int c);
    int a = c - S;
    logic [2:0] r = 3'b000;
    if (a >= 1) r = {hd[a] && !hd[a-1], hs[a] && !hs[a-1], hb[a] && !hb[a-1]};
    return r;
  endfunction
  function automatic logic [2:0] pri(input logic [2:0] e);
    return e[0] ? 3'b001 : e[1] ? 3'b010 : e[2] ? 3'b100 : 3'b000;
  endfunction
  function automatic bit elig(input logic [2:0] op, input logic [6:0] y);
    if (op == 3'b001 || op == 3'b010) return y == GY;
    if (op == 3'b100) return y < GY;
    return 0;
  endfunction
  function automatic int len_of(input logic [2:0] op);
    return op == 3'b001 ? 10 : op == 3'b010 ? 15 : 9;
  endfunction

  task automatic model_eval();
    e_upd  = (n % T) == T - 1;
    e_busy = n >= arm_s && n < idle_at;
    e_op   = (n >= arm_s && n <= issue_u) ? m_op : 3'b000;
  endtask
  // armed from next cycle; issued on the first update after that; busy for LEN update periods plus the final settle cycle
  task automatic arm(input logic [2:0] op);
    m_op = op;
    arm_s = n + 1;
    issue_u = n + 1 + (T - 1 - (n + 1) % T);
    idle_at = issue_u + (len_of(op) - 1) * T + 2;
  endtask
  task automatic step();
    logic [2:0] w;
    @(posedge clk);
    w = pri(edges(n));
    if (!(n >= arm_s && n < idle_at)) begin
      if (pend != 3'b000 && elig(pend, y_pos)) arm(pend);
      else if (w != 3'b000 && elig(w, y_pos)) arm(w);
      pend = 3'b000;
    end else if (BUF && w != 3'b000) pend = w;
    n++;
    hb[n] = key_big;
    hs[n] = key_small;
    hd[n] = key_drop;
    model_eval();
    @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    key_big = 0;
    key_small = 0;
    key_drop = 0;
    #1;
    checks++;
    if ({operation, busy, update} !== 5'b0) begin errors++; $display("FAIL reset_async got=%b exp=00000", {operation, busy, update}); end
    @(negedge clk);
    reset = 0;
    n = 0; arm_s = -1000; issue_u = -1000; idle_at = -1000; m_op = 0; pend = 0;
    foreach (hb[i]) begin hb[i] = 0; hs[i] = 0; hd[i] = 0; end
    model_eval();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({operation, busy, update} !== 5'b0) begin errors++; $display("FAIL reset_release got=%b exp=00000", {operation, busy, update}); end
  endtask

  task automatic test_tick();
    do_reset();
    repeat (20) begin
      step();
      checks++;
      if ({operation, busy, update} !== {3'b000, 1'b0, n % 4 == 3}) begin errors++; $display("FAIL tick n=%0d got=%b exp=%b", n, {operation, busy, update}, {3'b000, 1'b0, n % 4 == 3}); end
    end
  endtask

  task automatic test_big_jump();
    do_reset();
    y_pos = 7'd108;
    key_big = 1; step(); key_big = 0;
    repeat (4) begin
      step();
      checks++;
      if ({operation, busy, update} !== {e_op, e_busy, e_upd}) begin errors++; $display("FAIL big n=%0d got=%b exp=%b", n, {operation, busy, update}, {e_op, e_busy, e_upd}); end
    end
    while (n < idle_at + 3) begin
      step();
      checks++;
      if ({operation, busy, update} !== {e_op, e_busy, e_upd}) begin errors++; $display("FAIL big n=%0d got=%b exp=%b", n, {operation, busy, update}, {e_op, e_busy, e_upd}); end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    y_pos = 7'd108;
    key_big = 1; key_small = 1; step(); key_big = 0; key_small = 0;
    repeat (4) begin
      step();
      checks++;
      if ({operation, busy, update} !== {e_op, e_busy, e_upd}) begin errors++; $display("FAIL simul n=%0d got=%b exp=%b", n, {operation, busy, update}, {e_op, e_busy, e_upd}); end
    end
    while (n < idle_at + 6) begin
      step();
      checks++;
      if (operation === 3'b010 || {operation, busy, update} !== {e_op, e_busy, e_upd}) begin errors++; $display("FAIL simul n=%0d got=%b exp=%b", n, {operation, busy, update}, {e_op, e_busy, e_upd}); end
    end
  endtask

  task automatic test_drop();
    do_reset();
    y_pos = 7'd108;
    key_drop = 1; step(); key_drop = 0;
    repeat (12) begin
      step();
      checks++;
      if ({operation, busy} !== 4'b0000) begin errors++; $display("FAIL drop_ground n=%0d got=%b exp=0000", n, {operation, busy}); end
    end
    y_pos = 7'd90;
    key_drop = 1; step(); key_drop = 0;
    repeat (4) begin
      step();
      checks++;
      if ({operation, busy, update} !== {e_op, e_busy, e_upd}) begin errors++; $display("FAIL drop_air n=%0d got=%b exp=%b", n, {operation, busy, update}, {e_op, e_busy, e_upd}); end
    end
    while (n < idle_at + 3) begin
      step();
      checks++;
      if ({operation, busy, update} !== {e_op, e_busy, e_upd}) begin errors++; $display("FAIL drop_air n=%0d got=%b exp=%b", n, {operation, busy, update}, {e_op, e_busy, e_upd}); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    y_pos = 7'd108;
    key_small = 1; step(); key_small = 0;
    repeat (4) step();
    while (n < issue_u + 4 * T + 2) begin
      step();
      checks++;
      if ({operation, busy, update} !== {e_op, e_busy, e_upd}) begin errors++; $display("FAIL mid_run n=%0d got=%b exp=%b", n, {operation, busy, update}, {e_op, e_busy, e_upd}); end
    end
    do_reset();
    repeat (8) begin
      step();
      checks++;
      if ({operation, busy, update} !== {e_op, e_busy, e_upd}) begin errors++; $display("FAIL mid_restart n=%0d got=%b exp=%b", n, {operation, busy, update}, {e_op, e_busy, e_upd}); end
    end
    key_big = 1; step(); key_big = 0;
    while (n < 60) begin
      step();
      checks++;
      if ({operation, busy, update} !== {e_op, e_busy, e_upd}) begin errors++; $display("FAIL mid_rejump n=%0d got=%b exp=%b", n, {operation, busy, update}, {e_op, e_busy, e_upd}); end
    end
  endtask

  task automatic test_buffer();
    int t;
    do_reset();
    y_pos = 7'd108;
    key_big = 1; step(); key_big = 0;
    repeat (4) step();
    while (n < issue_u + 3) step();
    key_small = 1; step(); key_small = 0;
    t = idle_at;
    while (n < t + 1) begin
      step();
      checks++;
      if ({operation, busy, update} !== {e_op, e_busy, e_upd}) begin errors++; $display("FAIL buffer n=%0d got=%b exp=%b", n, {operation, busy, update}, {e_op, e_busy, e_upd}); end
    end
    checks++;
    if (operation !== (BUF ? 3'b010 : 3'b000)) begin errors++; $display("FAIL buffer_issue got=%b exp=%b", operation, BUF ? 3'b010 : 3'b000); end
    repeat (80) begin
      step();
      checks++;
      if ({operation, busy, update} !== {e_op, e_busy, e_upd}) begin errors++; $display("FAIL buffer_tail n=%0d got=%b exp=%b", n, {operation, busy, update}, {e_op, e_busy, e_upd}); end
    end
  endtask

  task automatic test_random();
    do_reset();
    repeat (1500) begin
      key_big = $urandom_range(0, 11) == 0;
      key_small = $urandom_range(0, 11) == 0;
      key_drop = $urandom_range(0, 11) == 0;
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 2))
          0: y_pos = 7'd108;
          1: y_pos = 7'd90;
          default: y_pos = 7'($urandom_range(0, 127));
        endcase
      end
      step();
      checks++;
      if ({operation, busy, update} !== {e_op, e_busy, e_upd}) begin errors++; $display("FAIL random n=%0d got=%b exp=%b", n, {operation, busy, update}, {e_op, e_busy, e_upd}); end
    end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_big_jump();
    test_simultaneous();
    test_drop();
    test_reset_mid();
    test_buffer();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
